// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and limits for the stopwatch lap core.
//   state_e     : control state (IDLE / RUN / STOP)
//   time_t      : packed {hour, min, sec, cs} time payload
//   time_inc()  : one-tick increment with full carry chain and 24h wrap
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    localparam int unsigned CS_W   = 7;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    localparam int unsigned CS_MAX   = 99;
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [CS_W-1:0]   cs;
    } time_t;

    // Advance by one centisecond; 23:59:59.99 rolls over to all zeros.
    function automatic time_t time_inc(input time_t t);
        time_t r;
        r = t;
        if (t.cs != CS_W'(CS_MAX)) begin
            r.cs = t.cs + CS_W'(1);
        end else begin
            r.cs = '0;
            if (t.sec != SEC_W'(SEC_MAX)) begin
                r.sec = t.sec + SEC_W'(1);
            end else begin
                r.sec = '0;
                if (t.min != MIN_W'(MIN_MAX)) begin
                    r.min = t.min + MIN_W'(1);
                end else begin
                    r.min = '0;
                    if (t.hour != HOUR_W'(HOUR_MAX)) begin
                        r.hour = t.hour + HOUR_W'(1);
                    end else begin
                        r.hour = '0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// stopwatch_tick_gen: prescaler producing one-cycle count ticks.
//   clk, reset : clock, async active-high reset
//   i_en       : count enable (held value when low)
//   i_clr      : synchronous zero of the prescaler
//   o_tick     : high for the cycle in which the prescaler sits at DIV-1
module stopwatch_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next prescaler value: clear wins, otherwise count modulo DIV while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = i_en && !i_clr && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core: cs/sec/min/hour stopwatch with lap capture and recall.
//   clk, reset                     : clock, async active-high reset
//   i_runstop/i_clear/i_lap/i_lap_view : one-cycle command pulses
//   i_mode / o_mode                : display page select, registered pass-through
//   o_cs/o_sec/o_min/o_hour        : live time or the selected lap entry
//   o_running                      : high in RUN
//   o_lap_count/o_lap_full         : stored lap count and full flag
//   o_viewing_lap                  : outputs show a stored lap rather than live time
module stopwatch_lap_core #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_runstop,
    input  logic                             i_clear,
    input  logic                             i_lap,
    input  logic                             i_lap_view,
    input  logic                             i_mode,
    output logic [6:0]                       o_cs,
    output logic [5:0]                       o_sec,
    output logic [5:0]                       o_min,
    output logic [4:0]                       o_hour,
    output logic                             o_mode,
    output logic                             o_running,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   o_lap_count,
    output logic                             o_lap_full,
    output logic                             o_viewing_lap
);

    import stopwatch_pkg::*;

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned LCW = $clog2(LAP_DEPTH + 1);

    state_e          state_q;
    time_t           time_q;
    time_t           laps_q [LAP_DEPTH];
    logic [LCW-1:0]  lap_cnt_q;
    logic [LCW-1:0]  view_q;
    logic            mode_q;

    logic            tick;
    logic            lap_full;
    logic            lap_take;
    logic            clear_fire;
    logic            viewing;
    time_t           disp;

    assign lap_full   = (lap_cnt_q == LCW'(LAP_DEPTH));
    assign clear_fire = (state_q == STOP) && i_clear;
    assign lap_take   = (state_q == RUN) && i_lap && !lap_full;
    assign viewing    = (view_q != lap_cnt_q);

    stopwatch_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .i_en   (state_q == RUN),
        .i_clr  (clear_fire),
        .o_tick (tick)
    );

    // Control FSM plus time, lap buffer and view index; view_q == lap_cnt_q means live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            time_q    <= '0;
            lap_cnt_q <= '0;
            view_q    <= '0;
            mode_q    <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                laps_q[i] <= '0;
            end
        end else begin
            mode_q <= i_mode;
            case (state_q)
                IDLE: begin
                    if (i_runstop) begin
                        state_q <= RUN;
                        view_q  <= lap_cnt_q;
                    end
                end
                RUN: begin
                    if (tick) begin
                        time_q <= time_inc(time_q);
                    end
                    // Capture the pre-tick value; view index follows the count to stay live.
                    if (lap_take) begin
                        for (int i = 0; i < LAP_DEPTH; i++) begin
                            if (lap_cnt_q == LCW'(i)) begin
                                laps_q[i] <= time_q;
                            end
                        end
                        lap_cnt_q <= lap_cnt_q + LCW'(1);
                        view_q    <= lap_cnt_q + LCW'(1);
                    end
                    if (i_runstop) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (i_clear) begin
                        state_q   <= IDLE;
                        time_q    <= '0;
                        lap_cnt_q <= '0;
                        view_q    <= '0;
                        for (int i = 0; i < LAP_DEPTH; i++) begin
                            laps_q[i] <= '0;
                        end
                    end else if (i_runstop) begin
                        state_q <= RUN;
                        view_q  <= lap_cnt_q;
                    end else if (i_lap_view && (lap_cnt_q != '0)) begin
                        view_q <= (view_q == lap_cnt_q) ? '0 : view_q + LCW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Display source: the selected lap entry, or live time.
    always_comb begin
        disp = time_q;
        for (int i = 0; i < LAP_DEPTH; i++) begin
            if (viewing && (view_q == LCW'(i))) begin
                disp = laps_q[i];
            end
        end
    end

    assign o_cs          = disp.cs;
    assign o_sec         = disp.sec;
    assign o_min         = disp.min;
    assign o_hour        = disp.hour;
    assign o_mode        = mode_q;
    assign o_running     = (state_q == RUN);
    assign o_lap_count   = lap_cnt_q;
    assign o_lap_full    = lap_full;
    assign o_viewing_lap = viewing;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// tb_stopwatch_lap_core: scenario tasks with a scoreboard of expected output
// vectors and expected lap contents (DIV = 10, LAP_DEPTH = 4).
module tb_stopwatch_lap_core;

    import stopwatch_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_runstop;
    logic       i_clear;
    logic       i_lap;
    logic       i_lap_view;
    logic       i_mode;
    logic [6:0] o_cs;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_mode;
    logic       o_running;
    logic [2:0] o_lap_count;
    logic       o_lap_full;
    logic       o_viewing_lap;

    int          total = 0;
    int          bad   = 0;
    logic [29:0] exp_q [$];
    time_t       lap_q [$];
    logic [29:0] got;
    logic [29:0] want;
    time_t       wrap_t;

    stopwatch_lap_core #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .LAP_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_runstop     (i_runstop),
        .i_clear       (i_clear),
        .i_lap         (i_lap),
        .i_lap_view    (i_lap_view),
        .i_mode        (i_mode),
        .o_cs          (o_cs),
        .o_sec         (o_sec),
        .o_min         (o_min),
        .o_hour        (o_hour),
        .o_mode        (o_mode),
        .o_running     (o_running),
        .o_lap_count   (o_lap_count),
        .o_lap_full    (o_lap_full),
        .o_viewing_lap (o_viewing_lap)
    );

    always #5 clk = ~clk;

    // Time reached after n ticks from zero.
    function automatic time_t t_of(input int n);
        time_t t;
        t.cs   = 7'(n % 100);
        t.sec  = 6'((n / 100) % 60);
        t.min  = 6'((n / 6000) % 60);
        t.hour = 5'((n / 360000) % 24);
        return t;
    endfunction

    function automatic logic [29:0] mk(input time_t t, input logic run, input logic [2:0] cnt,
                                       input logic full, input logic view);
        return {t, run, cnt, full, view};
    endfunction

    function automatic logic [29:0] obs();
        return {o_hour, o_min, o_sec, o_cs, o_running, o_lap_count, o_lap_full, o_viewing_lap};
    endfunction

    task automatic cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    // Drive the chosen pulses for exactly one rising edge; returns at the next falling edge.
    task automatic pulse(input logic rs, input logic clr, input logic lap, input logic lv);
        i_runstop  = rs;
        i_clear    = clr;
        i_lap      = lap;
        i_lap_view = lv;
        @(negedge clk);
        i_runstop  = 1'b0;
        i_clear    = 1'b0;
        i_lap      = 1'b0;
        i_lap_view = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_mode = 1'b0;
        exp_q.push_back(mk(t_of(0), 1'b0, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL reset_init got=%h want=%h", got, want); end
        total++;
        if (o_mode !== 1'b0) begin bad++; $display("FAIL reset_mode got=%b want=0", o_mode); end
        @(negedge clk);
        reset = 1'b0;
        pulse(1, 0, 0, 0);
        cycles(499);
        exp_q.push_back(mk(t_of(50), 1'b1, 3'd1, 1'b0, 1'b0));
        pulse(0, 0, 1, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL reset_prelap got=%h want=%h", got, want); end
        cycles(700);
        i_mode = 1'b1;
        #1;
        total++;
        if (o_mode !== 1'b0) begin bad++; $display("FAIL mode_latency got=%b want=0", o_mode); end
        @(negedge clk);
        total++;
        if (o_mode !== 1'b1) begin bad++; $display("FAIL mode_follow got=%b want=1", o_mode); end
        cycles(29);
        exp_q.push_back(mk(t_of(123), 1'b1, 3'd1, 1'b0, 1'b0));
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL reset_at_1_23 got=%h want=%h", got, want); end
        #2 reset = 1'b1;
        exp_q.push_back(mk(t_of(0), 1'b0, 3'd0, 1'b0, 1'b0));
        #1;
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL reset_async got=%h want=%h", got, want); end
        total++;
        if (o_mode !== 1'b0) begin bad++; $display("FAIL reset_async_mode got=%b want=0", o_mode); end
        @(negedge clk);
        reset = 1'b0;
        i_mode = 1'b0;
    endtask

    task automatic test_run_stop();
        pulse(1, 0, 0, 0);
        cycles(999);
        exp_q.push_back(mk(t_of(99), 1'b1, 3'd0, 1'b0, 1'b0));
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL run_0_99 got=%h want=%h", got, want); end
        cycles(1);
        exp_q.push_back(mk(t_of(100), 1'b1, 3'd0, 1'b0, 1'b0));
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL run_1_00 got=%h want=%h", got, want); end
        cycles(4);
        exp_q.push_back(mk(t_of(100), 1'b0, 3'd0, 1'b0, 1'b0));
        pulse(1, 0, 0, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL stop_enter got=%h want=%h", got, want); end
        cycles(7);
        exp_q.push_back(mk(t_of(100), 1'b0, 3'd0, 1'b0, 1'b0));
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL stop_hold got=%h want=%h", got, want); end
        pulse(1, 0, 0, 0);
        cycles(4);
        exp_q.push_back(mk(t_of(100), 1'b1, 3'd0, 1'b0, 1'b0));
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL resume_early got=%h want=%h", got, want); end
        cycles(1);
        exp_q.push_back(mk(t_of(101), 1'b1, 3'd0, 1'b0, 1'b0));
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL resume_tick got=%h want=%h", got, want); end
        exp_q.push_back(mk(t_of(101), 1'b1, 3'd0, 1'b0, 1'b0));
        pulse(0, 1, 0, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL clear_in_run got=%h want=%h", got, want); end
    endtask

    task automatic test_wrap();
        pulse(1, 0, 0, 0);
        wrap_t = t_of(8639999);
        force dut.time_q = wrap_t;
        @(negedge clk);
        release dut.time_q;
        exp_q.push_back(mk(t_of(8639999), 1'b0, 3'd0, 1'b0, 1'b0));
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL wrap_load got=%h want=%h", got, want); end
        pulse(1, 0, 0, 0);
        cycles(7);
        exp_q.push_back(mk(t_of(8639999), 1'b1, 3'd0, 1'b0, 1'b0));
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL wrap_before got=%h want=%h", got, want); end
        cycles(1);
        exp_q.push_back(mk(t_of(0), 1'b1, 3'd0, 1'b0, 1'b0));
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL wrap_after got=%h want=%h", got, want); end
        pulse(1, 0, 0, 0);
        exp_q.push_back(mk(t_of(0), 1'b0, 3'd0, 1'b0, 1'b0));
        pulse(0, 1, 0, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL clear_in_stop got=%h want=%h", got, want); end
    endtask

    task automatic test_laps();
        int lap_at [5] = '{25, 57, 130, 301, 410};
        int n;
        int k;
        time_t lt;
        pulse(1, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            k = lap_at[i];
            cycles(k - 1 - n);
            if (i < DEPTH) lap_q.push_back(t_of((k - 1) / 10));
            exp_q.push_back(mk(t_of(k / 10), 1'b1, 3'((i + 1 > DEPTH) ? DEPTH : i + 1),
                               (i + 1 >= DEPTH), 1'b0));
            pulse(0, 0, 1, 0);
            n = k;
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL lap_capture%0d got=%h want=%h", i, got, want); end
        end
        exp_q.push_back(mk(t_of(41), 1'b0, 3'd4, 1'b1, 1'b0));
        pulse(1, 0, 0, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL lap_stop got=%h want=%h", got, want); end
        exp_q.push_back(mk(t_of(41), 1'b0, 3'd4, 1'b1, 1'b0));
        pulse(0, 0, 1, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL lap_in_stop got=%h want=%h", got, want); end
        for (int i = 0; i < DEPTH; i++) begin
            pulse(0, 0, 0, 1);
            lt = lap_q.pop_front();
            got = obs(); want = mk(lt, 1'b0, 3'd4, 1'b1, 1'b1); total++;
            if (got !== want) begin bad++; $display("FAIL lap_entry%0d got=%h want=%h", i, got, want); end
        end
        exp_q.push_back(mk(t_of(41), 1'b0, 3'd4, 1'b1, 1'b0));
        pulse(0, 0, 0, 1);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL lap_back_live got=%h want=%h", got, want); end
    endtask

    task automatic test_lap_view();
        time_t lt;
        exp_q.push_back(mk(t_of(0), 1'b0, 3'd0, 1'b0, 1'b0));
        pulse(0, 1, 0, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL view_clear got=%h want=%h", got, want); end
        pulse(1, 0, 0, 0);
        cycles(32);
        lap_q.push_back(t_of(3));
        pulse(0, 0, 1, 0);
        cycles(44);
        lap_q.push_back(t_of(7));
        pulse(0, 0, 1, 0);
        cycles(16);
        exp_q.push_back(mk(t_of(9), 1'b0, 3'd2, 1'b0, 1'b0));
        pulse(1, 0, 0, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL view_stop got=%h want=%h", got, want); end
        for (int i = 0; i < 2; i++) begin
            pulse(0, 0, 0, 1);
            lt = lap_q.pop_front();
            got = obs(); want = mk(lt, 1'b0, 3'd2, 1'b0, 1'b1); total++;
            if (got !== want) begin bad++; $display("FAIL view_lap%0d got=%h want=%h", i, got, want); end
        end
        exp_q.push_back(mk(t_of(9), 1'b0, 3'd2, 1'b0, 1'b0));
        pulse(0, 0, 0, 1);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL view_live got=%h want=%h", got, want); end
        exp_q.push_back(mk(t_of(3), 1'b0, 3'd2, 1'b0, 1'b1));
        pulse(0, 0, 0, 1);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL view_wrap got=%h want=%h", got, want); end
        exp_q.push_back(mk(t_of(9), 1'b1, 3'd2, 1'b0, 1'b0));
        pulse(1, 0, 0, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL view_run_live got=%h want=%h", got, want); end
    endtask

    task automatic test_same_cycle();
        pulse(1, 0, 0, 0);
        exp_q.push_back(mk(t_of(0), 1'b0, 3'd0, 1'b0, 1'b0));
        pulse(1, 1, 0, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL clear_beats_run got=%h want=%h", got, want); end
        pulse(1, 0, 0, 0);
        cycles(19);
        lap_q.push_back(t_of(1));
        exp_q.push_back(mk(t_of(2), 1'b0, 3'd1, 1'b0, 1'b0));
        pulse(1, 0, 1, 0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL lap_and_stop got=%h want=%h", got, want); end
        pulse(0, 0, 0, 1);
        got = obs(); want = mk(lap_q.pop_front(), 1'b0, 3'd1, 1'b0, 1'b1); total++;
        if (got !== want) begin bad++; $display("FAIL lap_pre_tick got=%h want=%h", got, want); end
    endtask

    initial begin
        reset      = 1'b1;
        i_runstop  = 1'b0;
        i_clear    = 1'b0;
        i_lap      = 1'b0;
        i_lap_view = 1'b0;
        i_mode     = 1'b0;
        test_reset();
        test_run_stop();
        test_wrap();
        test_laps();
        test_lap_view();
        test_same_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap_core.md
# stopwatch_lap_core

Parametrised stopwatch datapath and control core that extends the plain two-field stopwatch to a full centisecond/second/minute/hour count with a lap-capture buffer and lap recall. It sits between the debounced button devices and the FND controller. It consumes single-cycle command pulses and presents the live time, or one stored lap, for display.

## Interface

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 100, count rate. CLK_HZ % TICK_HZ must equal 0, and DIV = CLK_HZ/TICK_HZ must be ≥ 2.
- LAP_DEPTH, 4, number of lap entries stored (≥ 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_runstop  in  1  one-cycle pulse; toggles run/stop.
- i_clear  in  1  one-cycle pulse; clears time and laps.
- i_lap  in  1  one-cycle pulse; captures current time.
- i_lap_view  in  1  one-cycle pulse; steps the displayed lap.
- i_mode  in  1  display-page select (0 = cs:sec, 1 = min:hour); passed through as o_mode.
- o_cs  out  7  centiseconds shown (0–99).
- o_sec  out  6  seconds shown (0–59).
- o_min  out  6  minutes shown (0–59).
- o_hour  out  5  hours shown (0–23).
- o_mode  out  1  registered copy of i_mode.
- o_running  out  1  high in RUN.
- o_lap_count  out  $clog2(LAP_DEPTH+1)  number of laps stored.
- o_lap_full  out  1  o_lap_count == LAP_DEPTH.
- o_viewing_lap  out  1  outputs show a stored lap, not live time.

## Operation

- States:
  - IDLE: time is zero and no laps are stored.
  - RUN: counting.
  - STOP: frozen, nonzero or with laps.
- Transitions:
  - IDLE → RUN on i_runstop.
  - RUN → STOP on i_runstop.
  - STOP → RUN on i_runstop.
  - STOP → IDLE on i_clear.
  - i_clear in IDLE or RUN is ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and produces a tick at DIV-1.
  - Holds its value in STOP, so the fraction is preserved across stop/resume.
  - Zeroed on clear.
- Counter chain on tick:
  - cs 99→0 carries into sec.
  - sec 59→0 carries into min.
  - min 59→0 carries into hour.
  - hour 23→0 wraps the whole count (23:59:59.99 → 00:00:00.00). No flag is raised.
- Lap capture:
  - i_lap in RUN writes {hour,min,sec,cs}, as registered in that cycle (before any same-cycle tick), to entry o_lap_count, then increments o_lap_count.
  - When full, i_lap is dropped and the buffer is unchanged.
  - i_lap in IDLE or STOP is ignored.
- Lap view:
  - view_idx ranges 0..o_lap_count, where o_lap_count means live.
  - Starts at live after reset or clear.
  - i_lap_view in STOP with o_lap_count > 0 advances view_idx, wrapping from live back to 0.
  - i_lap_view is ignored otherwise.
  - Entering RUN forces view_idx to live.
  - o_viewing_lap = (view_idx != o_lap_count).
- Same-cycle priority:
  - STOP: i_clear beats i_runstop beats i_lap_view; the lower-priority pulses are ignored that cycle.
  - RUN: i_runstop and i_lap are both honoured. The lap captures the pre-stop value, then the state goes to STOP.
- Clear zeroes the prescaler, time, all lap entries, o_lap_count and view_idx.

## Timing

- All state is in registers; the output mux is combinational from registers, so outputs change in the cycle after the causing edge.
- Tick increment is visible 1 cycle after the prescaler reaches DIV-1.
- First tick after IDLE → RUN arrives DIV cycles after the i_runstop edge.
- o_mode has 1-cycle latency.
- Lap write and count update are visible 1 cycle after the i_lap edge.
- Reset (asynchronous, any time including mid-count):
  - State = IDLE.
  - All time fields = 0; o_cs/o_sec/o_min/o_hour = 0.
  - Lap buffer zero; o_lap_count = 0.
  - o_running = 0, o_lap_full = 0, o_viewing_lap = 0, o_mode = 0.

## Structure

- Package stopwatch_pkg:
  - State enum (IDLE/RUN/STOP).
  - Limits CS_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Packed time struct {hour[4:0], min[5:0], sec[5:0], cs[6:0]}.
- Sub-module stopwatch_tick_gen:
  - Prescaler with enable and clear, parametrised by DIV.
  - Outputs a one-cycle o_tick.
- The lap buffer is a register array inside the core; no RAM inference.

## Test plan

Bench uses CLK_HZ=1000, TICK_HZ=100, so DIV=10.

1. Reset mid-RUN at 00:00:01.23 → next cycle all outputs 0, state IDLE, laps cleared.
2. Preload-free run of 100 ticks (1000 cycles) → o_sec=1, o_cs=0. Stop after 5 further cycles, resume → next tick after exactly 5 cycles.
3. Run to 23:59:59.99, one more tick → 00:00:00.00; no state change.
4. LAP_DEPTH=4: five i_lap pulses at distinct times → entries 0–3 hold the first four values; o_lap_full=1; fifth dropped.
5. In STOP with 2 laps, i_lap_view ×3 → lap0, lap1, live (o_viewing_lap 1,1,0). Then i_runstop → live view, RUN.
6. Same cycle in STOP: i_clear + i_runstop → IDLE, zero time, o_running=0. Same cycle in RUN: i_lap + i_runstop on a tick cycle → lap holds the pre-tick value, state STOP.
